sram_controller: RTL

//  Bridges the CPU data/instruction bus to one 1M x 32 asynchronous SRAM bank (BaseRAM or ExtRAM).

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM bank controller.
`timescale 1ns/1ps

package sram_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_BE_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } sram_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Single-beat valid/ready bridge from the CPU bus to one 1M x 32 asynchronous SRAM bank.
// All SRAM strobes come straight from flops, so they cannot glitch between states.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  ST_IDLE     | ready for a request, strobes inactive, data bus released
//  ST_RD       | ce_n/oe_n low for READ_CYCLES cycles, data sampled in last
//  ST_WR_SETUP | ce_n low, data and byte enables driven, we_n still high
//  ST_WR_PULSE | we_n low for WRITE_CYCLES cycles
//  ST_WR_HOLD  | we_n back high, data still driven so it holds past the edge
//  ST_DONE     | one-cycle response pulse, strobes inactive, bus released
`timescale 1ns/1ps

module sram_controller
    import sram_pkg::*;
#(
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 1
) (
    input  logic                   clk_50M,
    input  logic                   reset_btn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [31:0]            req_addr,
    input  logic [SRAM_BE_W-1:0]   req_be,
    input  logic [SRAM_DATA_W-1:0] req_wdata,
    output logic                   resp_valid,
    output logic [SRAM_DATA_W-1:0] resp_rdata,
    output logic [SRAM_ADDR_W-1:0] ram_addr,
    output logic                   ram_ce_n,
    output logic                   ram_oe_n,
    output logic                   ram_we_n,
    output logic [SRAM_BE_W-1:0]   ram_be_n,
    inout  wire  [SRAM_DATA_W-1:0] ram_data
);

    localparam int CNT_W = $clog2(max_int(READ_CYCLES, WRITE_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_CYCLES - 1);

    sram_state_t            state;
    sram_state_t            next_state;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_done;
    logic                   accept;
    logic [SRAM_BE_W-1:0]   be_q;
    logic [SRAM_DATA_W-1:0] wdata_q;
    logic                   drive_en;
    logic [SRAM_BE_W-1:0]   be_src;
    logic                   ce_n_d;
    logic                   oe_n_d;
    logic                   we_n_d;
    logic [SRAM_BE_W-1:0]   be_n_d;
    logic                   drive_d;
    logic                   unused_addr_bits;

    // Only the word address inside the 4 MB bank reaches the pins.
    assign unused_addr_bits = ^{req_addr[31:22], req_addr[1:0]};

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign cnt_done  = (cnt == '0);

    assign ram_data = drive_en ? wdata_q : 'z;

    // State register.
    always_ff @(posedge clk_50M or posedge reset_btn) begin
        if (reset_btn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:     if (accept) next_state = req_we ? ST_WR_SETUP : ST_RD;
            ST_RD:       if (cnt_done) next_state = ST_DONE;
            ST_WR_SETUP: next_state = ST_WR_PULSE;
            ST_WR_PULSE: if (cnt_done) next_state = ST_WR_HOLD;
            ST_WR_HOLD:  next_state = ST_DONE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Strobe values for the coming cycle, decoded from the next state so the
    // output flops line up exactly with the state they belong to.
    always_comb begin
        be_src  = (state == ST_IDLE) ? req_be : be_q;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        drive_d = 1'b0;
        unique case (next_state)
            ST_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                ce_n_d  = 1'b0;
                be_n_d  = ~be_src;
                drive_d = 1'b1;
            end
            ST_WR_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                be_n_d  = ~be_src;
                drive_d = 1'b1;
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase
    end

    // Registered strobes, driver enable and response pulse.
    always_ff @(posedge clk_50M or posedge reset_btn) begin
        if (reset_btn) begin
            ram_ce_n   <= 1'b1;
            ram_oe_n   <= 1'b1;
            ram_we_n   <= 1'b1;
            ram_be_n   <= '1;
            drive_en   <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            ram_ce_n   <= ce_n_d;
            ram_oe_n   <= oe_n_d;
            ram_we_n   <= we_n_d;
            ram_be_n   <= be_n_d;
            drive_en   <= drive_d;
            resp_valid <= (next_state == ST_DONE);
        end
    end

    // Down-counter timing RD and WR_PULSE; it parks at zero instead of wrapping.
    always_ff @(posedge clk_50M or posedge reset_btn) begin
        if (reset_btn) begin
            cnt <= '0;
        end else if (state == ST_IDLE && next_state == ST_RD) begin
            cnt <= RD_LOAD;
        end else if (state == ST_WR_SETUP) begin
            cnt <= WR_LOAD;
        end else if (!cnt_done) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Request capture at acceptance; the address then stays put for the whole access.
    always_ff @(posedge clk_50M or posedge reset_btn) begin
        if (reset_btn) begin
            ram_addr <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            ram_addr <= req_addr[21:2];
            be_q     <= req_be;
            wdata_q  <= req_wdata;
        end
    end

    // Read data capture at the end of the last RD cycle; held until the next read.
    always_ff @(posedge clk_50M or posedge reset_btn) begin
        if (reset_btn) begin
            resp_rdata <= '0;
        end else if (state == ST_RD && cnt_done) begin
            resp_rdata <= ram_data;
        end
    end

endmodule
